// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor update scheduler.
// Holds the default geometry, 2-bit counter encodings, saturating
// counter helpers, the queued update record and the scheduler FSM states.
package bp_pkg;

    localparam int ENTRY_BITS = 4;
    localparam int TAG_BITS   = 30 - ENTRY_BITS;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } pb_t;

    typedef enum logic {
        RUN,
        SWEEP
    } sched_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        hit;
        logic        way;
        logic [1:0]  pb;
    } upd_rec_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        if (v == ST) return ST;
        return v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        if (v == SNT) return SNT;
        return v - 2'd1;
    endfunction

endpackage

// File: rtl/bp_update_sched_if.sv
// Bundle between the pipeline (master) and the update scheduler (slave):
//   upd_*    resolved-branch update handshake from Execute
//   inv_*    predictor flush request / sweep status
//   wr_*     single write port towards the BHT/BTB arrays
interface bp_update_sched_if #(
    parameter int ENTRY_BITS = 4
);
    localparam int TAG_BITS = 30 - ENTRY_BITS;

    logic                  upd_valid;
    logic                  upd_ready;
    logic [31:0]           upd_pc;
    logic                  upd_taken;
    logic [31:0]           upd_target;
    logic                  upd_hit;
    logic                  upd_way;
    logic [1:0]            upd_pb;
    logic                  inv_req;
    logic                  inv_busy;
    logic                  wr_en;
    logic                  wr_all;
    logic [ENTRY_BITS-1:0] wr_set;
    logic                  wr_way;
    logic                  wr_v;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [1:0]            wr_pb;
    logic [31:0]           wr_ta;

    modport master (
        output upd_valid, upd_pc, upd_taken, upd_target, upd_hit, upd_way,
               upd_pb, inv_req,
        input  upd_ready, inv_busy, wr_en, wr_all, wr_set, wr_way, wr_v,
               wr_tag, wr_pb, wr_ta
    );

    modport slave (
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_hit, upd_way,
               upd_pb, inv_req,
        output upd_ready, inv_busy, wr_en, wr_all, wr_set, wr_way, wr_v,
               wr_tag, wr_pb, wr_ta
    );

endinterface

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO for queued predictor updates.
// Ports: clk, nrst (async active-low), push/pop/clear controls, din/dout
// data (dout shows the head), full/empty status. Clear wins over push/pop;
// push when full and pop when empty are ignored.
module bp_upd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
            else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bp_update_sched.sv
// Update scheduler between Execute and the predictor's single write port.
// Ports: clk, nrst (async active-low), bus (slave side of
// bp_update_sched_if). Buffers resolved-branch updates, picks the victim
// way from per-set LRU bits, formats the 2-bit counter write, and runs a
// one-set-per-cycle invalidation sweep on inv_req.
module bp_update_sched #(
    parameter int ENTRY_BITS = bp_pkg::ENTRY_BITS,
    parameter int PRD_BITS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic              clk,
    input logic              nrst,
    bp_update_sched_if.slave bus
);

    import bp_pkg::*;

    localparam int SETS     = 1 << ENTRY_BITS;
    localparam int TAG_BITS = 30 - ENTRY_BITS;

    sched_state_t          state;
    sched_state_t          state_nx;
    logic [ENTRY_BITS-1:0] cnt;
    logic [SETS-1:0]       lru;

    upd_rec_t              fifo_din;
    upd_rec_t              head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  clear;

    logic [ENTRY_BITS-1:0] head_set;
    logic [TAG_BITS-1:0]   head_tag;
    logic                  head_wr;
    logic                  head_way;
    logic [PRD_BITS-1:0]   head_pb;
    logic [1:0]            unused_pc_lsb;

    logic                  upd_wr_en;
    logic [ENTRY_BITS-1:0] upd_wr_set;
    logic                  upd_wr_way;
    logic [TAG_BITS-1:0]   upd_wr_tag;
    logic [PRD_BITS-1:0]   upd_wr_pb;
    logic [31:0]           upd_wr_ta;

    always_comb begin
        fifo_din        = '0;
        fifo_din.pc     = bus.upd_pc;
        fifo_din.taken  = bus.upd_taken;
        fifo_din.target = bus.upd_target;
        fifo_din.hit    = bus.upd_hit;
        fifo_din.way    = bus.upd_way;
        fifo_din.pb     = bus.upd_pb;
    end

    bp_upd_fifo #(
        .WIDTH($bits(upd_rec_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head decode: misses that were not taken are popped without a write.
    assign head_set      = head.pc[ENTRY_BITS+1:2];
    assign head_tag      = head.pc[31:ENTRY_BITS+2];
    assign unused_pc_lsb = head.pc[1:0];

    always_comb begin
        head_wr  = head.hit || head.taken;
        head_way = head.hit ? head.way : lru[head_set];
        if (!head.hit)      head_pb = PRD_BITS'(WT);
        else if (head.taken) head_pb = PRD_BITS'(sat_inc(head.pb));
        else                 head_pb = PRD_BITS'(sat_dec(head.pb));
    end

    // FSM: state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == SWEEP) ? cnt + ENTRY_BITS'(1) : '0;
        end
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (bus.inv_req) state_nx = SWEEP;
            SWEEP:   if (cnt == ENTRY_BITS'(SETS - 1)) state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // FSM: outputs. Sweep writes are decoded from the registered state and
    // count so that set 0 appears in the first busy cycle and inv_busy spans
    // exactly the SETS write cycles; update writes come from the pop register.
    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        clear = 1'b0;
        if (state == RUN) begin
            clear = bus.inv_req;
            push  = bus.upd_valid && !fifo_full && !bus.inv_req;
            pop   = !fifo_empty && !bus.inv_req;
        end

        bus.upd_ready = (state == RUN) && !fifo_full;
        bus.inv_busy  = (state == SWEEP);

        if (state == SWEEP) begin
            bus.wr_en  = 1'b1;
            bus.wr_all = 1'b1;
            bus.wr_set = cnt;
            bus.wr_way = 1'b0;
            bus.wr_v   = 1'b0;
            bus.wr_tag = '0;
            bus.wr_pb  = '0;
            bus.wr_ta  = '0;
        end else begin
            bus.wr_en  = upd_wr_en;
            bus.wr_all = 1'b0;
            bus.wr_set = upd_wr_set;
            bus.wr_way = upd_wr_way;
            bus.wr_v   = upd_wr_en;
            bus.wr_tag = upd_wr_tag;
            bus.wr_pb  = upd_wr_pb;
            bus.wr_ta  = upd_wr_ta;
        end
    end

    // Registered update write and LRU maintenance
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            upd_wr_en  <= 1'b0;
            upd_wr_set <= '0;
            upd_wr_way <= 1'b0;
            upd_wr_tag <= '0;
            upd_wr_pb  <= '0;
            upd_wr_ta  <= '0;
            lru        <= '0;
        end else begin
            upd_wr_en <= pop && head_wr;
            if (pop && head_wr) begin
                upd_wr_set     <= head_set;
                upd_wr_way     <= head_way;
                upd_wr_tag     <= head_tag;
                upd_wr_pb      <= head_pb;
                upd_wr_ta      <= head.target;
                lru[head_set]  <= ~head_way;
            end
            if (state == SWEEP) lru[cnt] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Self-checking bench for bp_update_sched: directed cases with literal
// expectations followed by randomized traffic compared every cycle against
// a queue-based behavioural model.
module tb_bp_update_sched;

    localparam int EB    = 4;
    localparam int SETS  = 16;
    localparam int DEPTH = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    bp_update_sched_if #(.ENTRY_BITS(EB)) bus ();

    bp_update_sched #(
        .ENTRY_BITS(EB),
        .PRD_BITS  (2),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        bit          taken;
        logic [31:0] target;
        bit          hit;
        bit          way;
        int          pb;
    } rec_t;

    rec_t        q[$];
    bit          m_lru[SETS];
    int          sweep_left = 0;
    int          sw_idx     = 0;
    bit          e_en       = 0;
    int          e_set      = 0;
    bit          e_way      = 0;
    logic [25:0] e_tag      = '0;
    int          e_pb       = 0;
    logic [31:0] e_ta       = '0;
    rec_t        m_r;
    bit          m_room;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q.delete();
            foreach (m_lru[i]) m_lru[i] = 1'b0;
            sweep_left = 0;
            sw_idx     = 0;
            e_en       = 0;
        end else if (sweep_left > 0) begin
            m_lru[sw_idx] = 1'b0;
            sw_idx++;
            sweep_left--;
            e_en = 0;
        end else if (bus.inv_req) begin
            q.delete();
            sweep_left = SETS;
            sw_idx     = 0;
            e_en       = 0;
        end else begin
            m_room = (q.size() < DEPTH);
            e_en   = 0;
            if (q.size() > 0) begin
                m_r = q.pop_front();
                if (m_r.hit) begin
                    e_en  = 1;
                    e_way = m_r.way;
                    if (m_r.taken) e_pb = (m_r.pb == 3) ? 3 : m_r.pb + 1;
                    else           e_pb = (m_r.pb == 0) ? 0 : m_r.pb - 1;
                end else if (m_r.taken) begin
                    e_en  = 1;
                    e_way = m_lru[(m_r.pc >> 2) % SETS];
                    e_pb  = 2;
                end
                if (e_en) begin
                    e_set = int'((m_r.pc >> 2) % SETS);
                    e_tag = 26'(m_r.pc >> (EB + 2));
                    e_ta  = m_r.target;
                    m_lru[e_set] = !e_way;
                end
            end
            if (bus.upd_valid && m_room) begin
                m_r.pc     = bus.upd_pc;
                m_r.taken  = bus.upd_taken;
                m_r.target = bus.upd_target;
                m_r.hit    = bus.upd_hit;
                m_r.way    = bus.upd_way;
                m_r.pb     = int'(bus.upd_pb);
                q.push_back(m_r);
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("upd_ready", 64'(bus.upd_ready), 64'(sweep_left == 0 && q.size() < DEPTH));
        check("inv_busy", 64'(bus.inv_busy), 64'(sweep_left > 0));
        if (sweep_left > 0) begin
            check("sw_wr_en", 64'(bus.wr_en), 64'(1));
            check("sw_wr_all", 64'(bus.wr_all), 64'(1));
            check("sw_wr_set", 64'(bus.wr_set), 64'(sw_idx));
            check("sw_wr_v", 64'(bus.wr_v), 64'(0));
            check("sw_wr_tag", 64'(bus.wr_tag), 64'(0));
            check("sw_wr_pb", 64'(bus.wr_pb), 64'(0));
            check("sw_wr_ta", 64'(bus.wr_ta), 64'(0));
        end else begin
            check("wr_en", 64'(bus.wr_en), 64'(e_en));
            check("wr_all", 64'(bus.wr_all), 64'(0));
            if (e_en) begin
                check("wr_set", 64'(bus.wr_set), 64'(e_set));
                check("wr_way", 64'(bus.wr_way), 64'(e_way));
                check("wr_v", 64'(bus.wr_v), 64'(1));
                check("wr_tag", 64'(bus.wr_tag), 64'(e_tag));
                check("wr_pb", 64'(bus.wr_pb), 64'(e_pb));
                check("wr_ta", 64'(bus.wr_ta), 64'(e_ta));
            end
        end
        if (!nrst) begin
            check("rst_wr_set", 64'(bus.wr_set), 64'(0));
            check("rst_wr_v", 64'(bus.wr_v), 64'(0));
            check("rst_wr_tag", 64'(bus.wr_tag), 64'(0));
            check("rst_wr_pb", 64'(bus.wr_pb), 64'(0));
            check("rst_wr_ta", 64'(bus.wr_ta), 64'(0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = '0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = '0;
        bus.upd_hit    = 1'b0;
        bus.upd_way    = 1'b0;
        bus.upd_pb     = '0;
        bus.inv_req    = 1'b0;
    endtask

    task automatic set_upd(input logic [31:0] pc, input bit taken, input logic [31:0] ta,
                           input bit hit, input bit way, input logic [1:0] pb);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = ta;
        bus.upd_hit    = hit;
        bus.upd_way    = way;
        bus.upd_pb     = pb;
    endtask

    // One update, then check the registered write one cycle after enqueue.
    task automatic one_upd(input string nm, input logic [31:0] pc, input bit taken,
                           input logic [31:0] ta, input bit hit, input bit way,
                           input logic [1:0] pb, input bit exp_en, input int exp_set,
                           input int exp_tag, input bit exp_way, input int exp_pb);
        set_upd(pc, taken, ta, hit, way, pb);
        cyc();
        idle();
        cyc();
        check({nm, "_en"}, 64'(bus.wr_en), 64'(exp_en));
        if (exp_en) begin
            check({nm, "_set"}, 64'(bus.wr_set), 64'(exp_set));
            check({nm, "_tag"}, 64'(bus.wr_tag), 64'(exp_tag));
            check({nm, "_way"}, 64'(bus.wr_way), 64'(exp_way));
            check({nm, "_pb"}, 64'(bus.wr_pb), 64'(exp_pb));
            check({nm, "_ta"}, 64'(bus.wr_ta), 64'(ta));
            check({nm, "_v"}, 64'(bus.wr_v), 64'(1));
        end
    endtask

    int          busy_n;
    int          stray;
    logic [3:0]  got[$];

    initial begin
        idle();
        nrst = 1'b0;
        repeat (3) cyc();
        check("reset_ready", 64'(bus.upd_ready), 64'(1));
        check("reset_busy", 64'(bus.inv_busy), 64'(0));
        check("reset_wr_en", 64'(bus.wr_en), 64'(0));
        nrst = 1'b1;
        cyc();

        // allocation and LRU toggling on set 2
        one_upd("miss_t1", 32'h0000_0048, 1, 32'h0000_0100, 0, 0, 2'd0, 1, 2, 1, 0, 2);
        one_upd("miss_t2", 32'h0000_0088, 1, 32'h0000_0200, 0, 0, 2'd0, 1, 2, 2, 1, 2);
        one_upd("miss_t3", 32'h0000_00C8, 1, 32'h0000_0300, 0, 0, 2'd0, 1, 2, 3, 0, 2);
        // hit counter updates
        one_upd("hit_st_t", 32'h0000_0100, 1, 32'h0000_0400, 1, 1, 2'd3, 1, 0, 4, 1, 3);
        one_upd("hit_snt_n", 32'h0000_0104, 0, 32'h0000_0500, 1, 0, 2'd0, 1, 1, 4, 0, 0);
        one_upd("hit_wt_n", 32'h0000_0108, 0, 32'h0000_0055, 1, 1, 2'd2, 1, 2, 4, 1, 1);
        one_upd("miss_nt", 32'h0000_010C, 0, 32'h0000_0600, 0, 0, 2'd0, 0, 0, 0, 0, 0);

        // five back-to-back updates, one write per cycle in order
        got.delete();
        for (int i = 0; i < 5; i++) begin
            set_upd(32'h0000_2000 + 32'((i + 3) * 4), 1, 32'h0000_1000 + 32'(i), 0, 0, 2'd0);
            cyc();
            if (bus.wr_en) got.push_back(bus.wr_set);
        end
        idle();
        repeat (4) begin
            cyc();
            if (bus.wr_en) got.push_back(bus.wr_set);
        end
        check("b2b_count", 64'(got.size()), 64'(5));
        for (int i = 0; i < 5 && i < got.size(); i++)
            check("b2b_order", 64'(got[i]), 64'(i + 3));

        // flush with an entry queued and an update in the request cycle
        set_upd(32'h0000_3008, 1, 32'h0000_7000, 0, 0, 2'd0);
        cyc();
        set_upd(32'h0000_300C, 1, 32'h0000_7004, 0, 0, 2'd0);
        bus.inv_req = 1'b1;
        cyc();
        idle();
        busy_n = 0;
        stray  = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.inv_busy) begin
                check("sweep_set", 64'(bus.wr_set), 64'(busy_n));
                check("sweep_all", 64'(bus.wr_all), 64'(1));
                busy_n++;
            end else if (bus.wr_en) begin
                stray++;
            end
            if (k == 4) bus.inv_req = 1'b1;
            cyc();
            bus.inv_req = 1'b0;
        end
        check("sweep_len", 64'(busy_n), 64'(16));
        check("sweep_stray", 64'(stray), 64'(0));
        check("sweep_ready", 64'(bus.upd_ready), 64'(1));
        // set 1 had lru=1 before the sweep; cleared LRU allocates way 0
        one_upd("post_sweep", 32'h0000_0104, 1, 32'h0000_0900, 0, 0, 2'd0, 1, 1, 4, 0, 2);

        // reset in the middle of a sweep
        one_upd("pre_rst", 32'h0000_1024, 1, 32'h0000_0A00, 0, 0, 2'd0, 1, 9, 64, 0, 2);
        bus.inv_req = 1'b1;
        cyc();
        idle();
        repeat (7) cyc();
        check("sweep7_set", 64'(bus.wr_set), 64'(7));
        nrst = 1'b0;
        #1;
        check("midrst_wr_en", 64'(bus.wr_en), 64'(0));
        check("midrst_wr_all", 64'(bus.wr_all), 64'(0));
        check("midrst_wr_set", 64'(bus.wr_set), 64'(0));
        check("midrst_busy", 64'(bus.inv_busy), 64'(0));
        check("midrst_ready", 64'(bus.upd_ready), 64'(1));
        cyc();
        nrst = 1'b1;
        cyc();
        check("after_rst_busy", 64'(bus.inv_busy), 64'(0));
        one_upd("cold_alloc", 32'h0000_1024, 1, 32'h0000_0B00, 0, 0, 2'd0, 1, 9, 64, 0, 2);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            idle();
            if ($urandom_range(99) < 60) begin
                set_upd({26'($urandom_range(3)), 4'($urandom_range(15)), 2'b00},
                        1'($urandom_range(1)), $urandom, 1'($urandom_range(1)),
                        1'($urandom_range(1)), 2'($urandom_range(3)));
            end
            if ($urandom_range(99) < 2) bus.inv_req = 1'b1;
            cyc();
        end
        idle();
        repeat (20) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
